// File: rtl/gpioemu_master_if.sv
// gpioemu_master_if
// Groups the command, response and peripheral strobe-bus signals of the
// gpioemu_master. The "master" modport is the view of gpioemu_master itself;
// the "slave" modport is the view of the surrounding logic, which provides the
// host command/response side and the peripheral read data.
//
// Signals:
//   cmd_valid/cmd_ready, cmd_a1/cmd_a2      command port (24-bit operands)
//   rsp_valid/rsp_ready, rsp_w/rsp_l,
//   rsp_ovf/rsp_timeout                     response port
//   saddress, swr, srd, sdata_out           strobe bus driven to the peripheral
//   sdata_in                                read data returned by the peripheral
interface gpioemu_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [23:0] cmd_a1;
  logic [23:0] cmd_a2;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_w;
  logic [23:0] rsp_l;
  logic        rsp_ovf;
  logic        rsp_timeout;
  logic [15:0] saddress;
  logic        swr;
  logic        srd;
  logic [31:0] sdata_out;
  logic [31:0] sdata_in;

  modport master (
    input  cmd_valid, cmd_a1, cmd_a2, rsp_ready, sdata_in,
    output cmd_ready, rsp_valid, rsp_w, rsp_l, rsp_ovf, rsp_timeout,
           saddress, swr, srd, sdata_out
  );

  modport slave (
    output cmd_valid, cmd_a1, cmd_a2, rsp_ready, sdata_in,
    input  cmd_ready, rsp_valid, rsp_w, rsp_l, rsp_ovf, rsp_timeout,
           saddress, swr, srd, sdata_out
  );
endinterface

// File: rtl/gpioemu_master.sv
// gpioemu_master
// Bus initiator for the multiply/popcount GPIO peripheral. A command carries
// two 24-bit operands; the master writes A1, A2 and the start register, polls
// the status register until it reports ready (or the poll limit expires),
// reads the product low word W and popcount L, and presents them on the
// response port.
//
// Ports:
//   clk          single clock, rising edge
//   n_reset      synchronous reset, active HIGH (name kept for compatibility)
//   bus          gpioemu_master_if.master: command, response and strobe bus
//   o_dbg_state  current FSM state, for observation only
//
// Handshakes: a transfer happens on a rising clock edge where both valid and
// ready are high. cmd_ready is high only in IDLE. rsp_valid is high only in
// RESP, and once raised it stays high with all rsp_* stable until rsp_ready.
//
// Every bus access is SETUP_CYCLES of address/data with strobe low,
// STROBE_CYCLES with strobe high, then one HOLD cycle with strobe low. Read
// data are captured at the edge ending the HOLD cycle.
module gpioemu_master #(
  parameter int unsigned SETUP_CYCLES  = 1,
  parameter int unsigned STROBE_CYCLES = 2,
  parameter int unsigned POLL_LIMIT    = 1024
) (
  input  logic             clk,
  input  logic             n_reset,
  gpioemu_master_if.master bus,
  output logic [3:0]       o_dbg_state
);

  localparam logic [15:0] ADDR_A1 = 16'h037F;
  localparam logic [15:0] ADDR_A2 = 16'h0388;
  localparam logic [15:0] ADDR_CS = 16'h03A0;
  localparam logic [15:0] ADDR_W  = 16'h0390;
  localparam logic [15:0] ADDR_L  = 16'h0398;

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_WR_A1   = 4'd1;
  localparam logic [3:0] S_WR_A2   = 4'd2;
  localparam logic [3:0] S_WR_GO   = 4'd3;
  localparam logic [3:0] S_RD_STAT = 4'd4;
  localparam logic [3:0] S_RD_W    = 4'd5;
  localparam logic [3:0] S_RD_L    = 4'd6;
  localparam logic [3:0] S_RESP    = 4'd7;

  localparam logic [1:0] PH_SETUP  = 2'd0;
  localparam logic [1:0] PH_STROBE = 2'd1;
  localparam logic [1:0] PH_HOLD   = 2'd2;

  localparam int unsigned PW = $clog2(POLL_LIMIT + 1);

  logic [3:0]    r_state;
  logic [1:0]    r_phase;
  logic [15:0]   r_cnt;
  logic [PW-1:0] r_poll;
  logic [23:0]   r_a2;
  logic [15:0]   r_saddress;
  logic [31:0]   r_sdata_out;
  logic          r_swr;
  logic          r_srd;
  logic [31:0]   r_rsp_w;
  logic [23:0]   r_rsp_l;
  logic          r_rsp_ovf;
  logic          r_rsp_timeout;

  logic          w_is_wr;
  logic          w_poll_more;
  logic [3:0]    w_next;

  function automatic logic [15:0] f_addr(input logic [3:0] s);
    case (s)
      S_WR_A1:           f_addr = ADDR_A1;
      S_WR_A2:           f_addr = ADDR_A2;
      S_WR_GO, S_RD_STAT: f_addr = ADDR_CS;
      S_RD_W:            f_addr = ADDR_W;
      S_RD_L:            f_addr = ADDR_L;
      default:           f_addr = 16'h0000;
    endcase
  endfunction

  assign w_is_wr     = (r_state == S_WR_A1) || (r_state == S_WR_A2) || (r_state == S_WR_GO);
  // Another status read is allowed only while the total stays below the limit.
  assign w_poll_more = ((32'(r_poll) + 32'd1) < POLL_LIMIT);

  // State that follows the access currently in its HOLD cycle.
  always_comb begin
    w_next = S_IDLE;
    case (r_state)
      S_WR_A1:   w_next = S_WR_A2;
      S_WR_A2:   w_next = S_WR_GO;
      S_WR_GO:   w_next = S_RD_STAT;
      S_RD_STAT: begin
        if (bus.sdata_in[1])  w_next = S_RD_W;
        else if (w_poll_more) w_next = S_RD_STAT;
        else                  w_next = S_RESP;
      end
      S_RD_W:    w_next = S_RD_L;
      S_RD_L:    w_next = S_RESP;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (n_reset) begin
      r_state       <= S_IDLE;
      r_phase       <= PH_SETUP;
      r_cnt         <= '0;
      r_poll        <= '0;
      r_a2          <= '0;
      r_saddress    <= '0;
      r_sdata_out   <= '0;
      r_swr         <= 1'b0;
      r_srd         <= 1'b0;
      r_rsp_w       <= '0;
      r_rsp_l       <= '0;
      r_rsp_ovf     <= 1'b0;
      r_rsp_timeout <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            // A1 goes straight onto the data bus; only A2 needs holding.
            r_a2          <= bus.cmd_a2;
            r_poll        <= '0;
            r_state       <= S_WR_A1;
            r_phase       <= PH_SETUP;
            r_cnt         <= '0;
            r_saddress    <= ADDR_A1;
            r_sdata_out   <= {8'h00, bus.cmd_a1};
            r_rsp_w       <= '0;
            r_rsp_l       <= '0;
            r_rsp_ovf     <= 1'b0;
            r_rsp_timeout <= 1'b0;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) r_state <= S_IDLE;
        end
        default: begin
          case (r_phase)
            PH_SETUP: begin
              if (r_cnt == 16'(SETUP_CYCLES - 1)) begin
                r_phase <= PH_STROBE;
                r_cnt   <= '0;
                if (w_is_wr) r_swr <= 1'b1;
                else         r_srd <= 1'b1;
              end else begin
                r_cnt <= r_cnt + 16'd1;
              end
            end
            PH_STROBE: begin
              if (r_cnt == 16'(STROBE_CYCLES - 1)) begin
                r_phase <= PH_HOLD;
                r_cnt   <= '0;
                r_swr   <= 1'b0;
                r_srd   <= 1'b0;
              end else begin
                r_cnt <= r_cnt + 16'd1;
              end
            end
            default: begin
              r_phase <= PH_SETUP;
              r_cnt   <= '0;
              r_state <= w_next;
              case (r_state)
                S_RD_STAT: begin
                  if (bus.sdata_in[1]) begin
                    r_rsp_ovf <= ~bus.sdata_in[0];
                  end else if (w_poll_more) begin
                    r_poll <= r_poll + PW'(1);
                  end else begin
                    r_rsp_timeout <= 1'b1;
                    r_rsp_w       <= '0;
                    r_rsp_l       <= '0;
                    r_rsp_ovf     <= 1'b0;
                  end
                end
                S_RD_W:  r_rsp_w <= bus.sdata_in;
                S_RD_L:  r_rsp_l <= bus.sdata_in[23:0];
                default: ;
              endcase
              // Address/data change only here, so they are new from the
              // first SETUP cycle of the next access. In RESP they are held.
              if (w_next != S_RESP) begin
                r_saddress  <= f_addr(w_next);
                r_sdata_out <= (w_next == S_WR_A2) ? {8'h00, r_a2} : 32'h0;
              end
            end
          endcase
        end
      endcase
    end
  end

  assign bus.cmd_ready   = (r_state == S_IDLE);
  assign bus.rsp_valid   = (r_state == S_RESP);
  assign bus.rsp_w       = r_rsp_w;
  assign bus.rsp_l       = r_rsp_l;
  assign bus.rsp_ovf     = r_rsp_ovf;
  assign bus.rsp_timeout = r_rsp_timeout;
  assign bus.saddress    = r_saddress;
  assign bus.sdata_out   = r_sdata_out;
  assign bus.swr         = r_swr;
  assign bus.srd         = r_srd;
  assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_gpioemu_master.sv
// tb_gpioemu_master
// Directed bench for gpioemu_master. u0 uses default timing; u1 uses
// SETUP_CYCLES=2, STROBE_CYCLES=3, POLL_LIMIT=4. A responder per instance
// returns register contents on the rising edge of srd; monitors log bus
// writes, reads and strobe edges for the main sequence to check.
module tb_gpioemu_master;

  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_RESP = 4'd7;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic n_reset;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  gpioemu_master_if b0 ();
  gpioemu_master_if b1 ();
  logic [3:0] dbg0, dbg1;

  gpioemu_master u0 (
    .clk(clk), .n_reset(n_reset), .bus(b0.master), .o_dbg_state(dbg0)
  );

  gpioemu_master #(.SETUP_CYCLES(2), .STROBE_CYCLES(3), .POLL_LIMIT(4)) u1 (
    .clk(clk), .n_reset(n_reset), .bus(b1.master), .o_dbg_state(dbg1)
  );

  // ---------------- peripheral responder ----------------
  logic [1:0]  stat0, stat1;
  logic [31:0] w0v, w1v;
  logic [23:0] l0v, l1v;
  logic [31:0] rd0 = 32'h0;
  logic [31:0] rd1 = 32'h0;
  logic        q0_srd = 1'b0;
  logic        q1_srd = 1'b0;

  function automatic logic [31:0] f_rd(input logic [15:0] a, input logic [1:0] s,
                                       input logic [31:0] w, input logic [23:0] l);
    case (a)
      16'h03A0: f_rd = {30'h0, s};
      16'h0390: f_rd = w;
      16'h0398: f_rd = {8'h00, l};
      default:  f_rd = 32'hDEADBEEF;
    endcase
  endfunction

  always @(posedge clk) begin
    if (b0.srd && !q0_srd) rd0 <= f_rd(b0.saddress, stat0, w0v, l0v);
    if (b1.srd && !q1_srd) rd1 <= f_rd(b1.saddress, stat1, w1v, l1v);
    q0_srd <= b0.srd;
    q1_srd <= b1.srd;
  end

  assign b0.sdata_in = rd0;
  assign b1.sdata_in = rd1;

  // ---------------- bus monitors ----------------
  int          cyc = 0;
  logic [15:0] wr0_a[$];
  logic [31:0] wr0_d[$];
  logic [15:0] rd0_a[$];
  logic [15:0] wr1_a[$];
  logic [15:0] rd1_a[$];
  int          rise1[$];
  int          fall1[$];
  int          ovl0 = 0;
  int          ovl1 = 0;
  int          viol1 = 0;
  logic        p0_swr = 1'b0, p0_srd = 1'b0;
  logic        p1_swr = 1'b0, p1_srd = 1'b0;
  logic [15:0] p1_addr = 16'h0;
  logic [31:0] p1_data = 32'h0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (b0.swr && !p0_swr) begin wr0_a.push_back(b0.saddress); wr0_d.push_back(b0.sdata_out); end
    if (b0.srd && !p0_srd) rd0_a.push_back(b0.saddress);
    if (b0.swr && b0.srd) ovl0 <= ovl0 + 1;
    if (b1.swr && !p1_swr) wr1_a.push_back(b1.saddress);
    if (b1.srd && !p1_srd) rd1_a.push_back(b1.saddress);
    if (b1.swr && b1.srd) ovl1 <= ovl1 + 1;
    if ((b1.swr | b1.srd) && !(p1_swr | p1_srd)) rise1.push_back(cyc);
    if (!(b1.swr | b1.srd) && (p1_swr | p1_srd)) fall1.push_back(cyc);
    // Address/data may only move while the strobe is low and was low before.
    if (((b1.saddress != p1_addr) || (b1.sdata_out != p1_data)) &&
        (b1.swr || b1.srd || p1_swr || p1_srd)) viol1 <= viol1 + 1;
    p0_swr  <= b0.swr;
    p0_srd  <= b0.srd;
    p1_swr  <= b1.swr;
    p1_srd  <= b1.srd;
    p1_addr <= b1.saddress;
    p1_data <= b1.sdata_out;
  end

  // ---------------- checker / driver tasks ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offers one command and waits (bounded) for rsp_valid. lat counts edges
  // after the accepting edge at which rsp_valid is first seen high.
  task automatic run(input int k, input logic [23:0] a1, input logic [23:0] a2, output int lat);
    if (k == 0) begin b0.cmd_a1 = a1; b0.cmd_a2 = a2; b0.cmd_valid = 1'b1; end
    else        begin b1.cmd_a1 = a1; b1.cmd_a2 = a2; b1.cmd_valid = 1'b1; end
    @(negedge clk);
    b0.cmd_valid = 1'b0;
    b1.cmd_valid = 1'b0;
    lat = 0;
    while ((((k == 0) ? b0.rsp_valid : b1.rsp_valid) == 1'b0) && (lat < 400)) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic ack(input int k);
    if (k == 0) b0.rsp_ready = 1'b1; else b1.rsp_ready = 1'b1;
    @(negedge clk);
    b0.rsp_ready = 1'b0;
    b1.rsp_ready = 1'b0;
    chk("rsp_valid_drop", (k == 0) ? b0.rsp_valid : b1.rsp_valid, 64'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int lat, wi, ri;
    n_reset = 1'b1;
    b0.cmd_valid = 1'b0; b0.cmd_a1 = '0; b0.cmd_a2 = '0; b0.rsp_ready = 1'b0;
    b1.cmd_valid = 1'b0; b1.cmd_a1 = '0; b1.cmd_a2 = '0; b1.rsp_ready = 1'b0;
    stat0 = 2'b00; w0v = '0; l0v = '0;
    stat1 = 2'b00; w1v = '0; l1v = '0;
    repeat (3) @(negedge clk);

    // Reset values
    chk("rst_cmd_ready", b0.cmd_ready, 64'd1);
    chk("rst_rsp_valid", b0.rsp_valid, 64'd0);
    chk("rst_rsp_w", b0.rsp_w, 64'd0);
    chk("rst_rsp_l", b0.rsp_l, 64'd0);
    chk("rst_rsp_ovf", b0.rsp_ovf, 64'd0);
    chk("rst_rsp_timeout", b0.rsp_timeout, 64'd0);
    chk("rst_saddress", b0.saddress, 64'd0);
    chk("rst_sdata_out", b0.sdata_out, 64'd0);
    chk("rst_strobes", {b0.srd, b0.swr}, 64'd0);
    chk("rst_state", dbg0, S_IDLE);
    n_reset = 1'b0;
    @(negedge clk);

    // Basic transaction: 3 x 5
    stat0 = 2'b11; w0v = 32'd15; l0v = 24'd4;
    wi = wr0_a.size(); ri = rd0_a.size();
    run(0, 24'd3, 24'd5, lat);
    chk("t1_latency", lat, 64'd24);
    chk("t1_rsp_w", b0.rsp_w, 64'd15);
    chk("t1_rsp_l", b0.rsp_l, 64'd4);
    chk("t1_rsp_ovf", b0.rsp_ovf, 64'd0);
    chk("t1_rsp_timeout", b0.rsp_timeout, 64'd0);
    chk("t1_wr_count", wr0_a.size() - wi, 64'd3);
    chk("t1_wr0", {wr0_a[wi], wr0_d[wi]}, {16'h037F, 32'd3});
    chk("t1_wr1", {wr0_a[wi+1], wr0_d[wi+1]}, {16'h0388, 32'd5});
    chk("t1_wr2", {wr0_a[wi+2], wr0_d[wi+2]}, {16'h03A0, 32'd0});
    chk("t1_rd_count", rd0_a.size() - ri, 64'd3);
    chk("t1_rd0", rd0_a[ri], 64'h03A0);
    chk("t1_rd1", rd0_a[ri+1], 64'h0390);
    chk("t1_rd2", rd0_a[ri+2], 64'h0398);

    // Back-pressure with a competing command
    b0.cmd_a1 = 24'h11; b0.cmd_a2 = 24'h22; b0.cmd_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_rsp_valid", b0.rsp_valid, 64'd1);
      chk("bp_cmd_ready", b0.cmd_ready, 64'd0);
      chk("bp_rsp_w", b0.rsp_w, 64'd15);
      chk("bp_rsp_l", b0.rsp_l, 64'd4);
    end
    b0.rsp_ready = 1'b1;
    @(negedge clk);
    b0.rsp_ready = 1'b0;
    b0.cmd_valid = 1'b0;
    chk("bp_rsp_valid_drop", b0.rsp_valid, 64'd0);
    chk("bp_cmd_ready_idle", b0.cmd_ready, 64'd1);
    repeat (8) @(negedge clk);
    chk("bp_cmd_ignored", wr0_a.size() - wi, 64'd3);
    chk("bp_state_idle", dbg0, S_IDLE);

    // Overflowing product
    stat0 = 2'b10; w0v = 32'hFE000001; l0v = 24'd8;
    wi = wr0_a.size();
    run(0, 24'hFFFFFF, 24'hFFFFFF, lat);
    chk("t2_latency", lat, 64'd24);
    chk("t2_rsp_ovf", b0.rsp_ovf, 64'd1);
    chk("t2_rsp_w", b0.rsp_w, 64'hFE000001);
    chk("t2_rsp_l", b0.rsp_l, 64'd8);
    chk("t2_rsp_timeout", b0.rsp_timeout, 64'd0);
    chk("t2_wr_a1", {wr0_a[wi], wr0_d[wi]}, {16'h037F, 32'h00FFFFFF});
    chk("t2_wr_a2", {wr0_a[wi+1], wr0_d[wi+1]}, {16'h0388, 32'h00FFFFFF});
    ack(0);

    // Reset during second STROBE cycle of WR_A2
    stat0 = 2'b11;
    b0.cmd_a1 = 24'd7; b0.cmd_a2 = 24'd9; b0.cmd_valid = 1'b1;
    @(negedge clk);
    b0.cmd_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("rs_pre_swr", b0.swr, 64'd1);
    chk("rs_pre_addr", b0.saddress, 64'h0388);
    chk("rs_pre_data", b0.sdata_out, 64'd9);
    n_reset = 1'b1;
    @(negedge clk);
    n_reset = 1'b0;
    chk("rs_swr", b0.swr, 64'd0);
    chk("rs_saddress", b0.saddress, 64'd0);
    chk("rs_cmd_ready", b0.cmd_ready, 64'd1);
    chk("rs_rsp_valid", b0.rsp_valid, 64'd0);
    w0v = 32'h01234560; l0v = 24'd9;
    wi = wr0_a.size();
    run(0, 24'h123456, 24'h000010, lat);
    chk("rs_latency", lat, 64'd24);
    chk("rs_wr_count", wr0_a.size() - wi, 64'd3);
    chk("rs_wr_a1", {wr0_a[wi], wr0_d[wi]}, {16'h037F, 32'h00123456});
    chk("rs_wr_a2", {wr0_a[wi+1], wr0_d[wi+1]}, {16'h0388, 32'h00000010});
    chk("rs_rsp_w", b0.rsp_w, 64'h01234560);
    chk("rs_rsp_l", b0.rsp_l, 64'd9);
    ack(0);
    chk("u0_no_overlap", ovl0, 64'd0);

    // u1: stretched timing, normal completion (3 x 11)
    stat1 = 2'b11; w1v = 32'h21; l1v = 24'd2;
    run(1, 24'd3, 24'd11, lat);
    chk("u1_latency", lat, 64'd36);
    chk("u1_rsp_w", b1.rsp_w, 64'h21);
    chk("u1_rsp_l", b1.rsp_l, 64'd2);
    chk("u1_rsp_timeout", b1.rsp_timeout, 64'd0);
    ack(1);

    // u1: status stuck at not-ready -> timeout after 4 polls
    stat1 = 2'b01; w1v = 32'hAAAAAAAA; l1v = 24'h5555;
    wi = wr1_a.size(); ri = rd1_a.size();
    run(1, 24'd2, 24'd2, lat);
    chk("to_latency", lat, 64'd42);
    chk("to_rsp_timeout", b1.rsp_timeout, 64'd1);
    chk("to_rsp_w", b1.rsp_w, 64'd0);
    chk("to_rsp_l", b1.rsp_l, 64'd0);
    chk("to_rsp_ovf", b1.rsp_ovf, 64'd0);
    chk("to_wr_count", wr1_a.size() - wi, 64'd3);
    chk("to_rd_count", rd1_a.size() - ri, 64'd4);
    for (int i = ri; i < rd1_a.size(); i++) chk("to_rd_addr", rd1_a[i], 64'h03A0);
    chk("to_edge_pairs", fall1.size(), rise1.size());
    for (int i = 0; i < rise1.size() && i < fall1.size(); i++)
      chk("u1_strobe_width", fall1[i] - rise1[i], 64'd3);
    for (int i = rise1.size() - 7; i < rise1.size() - 1; i++)
      if (i >= 0 && i + 1 < rise1.size() && i < fall1.size())
        chk("u1_strobe_gap", rise1[i+1] - fall1[i], 64'd3);
    chk("u1_pulse_count", rise1.size(), 64'd13);
    chk("u1_addr_stable", viol1, 64'd0);
    chk("u1_no_overlap", ovl1, 64'd0);
    ack(1);
    chk("u1_state_idle", dbg1, S_IDLE);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/gpioemu_master.md
# gpioemu_master

Bus initiator that drives the multiply/popcount GPIO peripheral over its `saddress`/`srd`/`swr`/`sdata` strobe bus. It accepts a 24×24 operand pair on a valid/ready command port and runs the full peripheral transaction: write A1, write A2, write start, poll status, read W, read L. It returns product low word, popcount, overflow and timeout flags on a valid/ready response port. It sits between host-side logic (or a testbench CPU model) and the peripheral, replacing software-driven register accesses.

## Interface
- `SETUP_CYCLES`, 1: cycles address/data are stable before strobe rises (≥1).
- `STROBE_CYCLES`, 2: cycles `srd`/`swr` held high (≥1).
- `POLL_LIMIT`, 1024: maximum status reads before timeout (≥1).
- `clk` in 1: single clock; all logic on rising edge.
- `n_reset` in 1: reset, synchronous, active-high (asserted = 1; name kept for bus compatibility).
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: master idle, command accepted when both high.
- `cmd_a1` in 24: first operand.
- `cmd_a2` in 24: second operand.
- `rsp_valid` out 1: result available.
- `rsp_ready` in 1: result consumed when both high.
- `rsp_w` out 32: product bits [31:0].
- `rsp_l` out 24: popcount.
- `rsp_ovf` out 1: product exceeded 32 bits (status bit0 = 0).
- `rsp_timeout` out 1: status never showed ready.
- `saddress` out 16: bus address.
- `swr` out 1: write strobe; peripheral captures on rising edge.
- `srd` out 1: read strobe; peripheral updates read data on rising edge.
- `sdata_out` out 32: write data to peripheral.
- `sdata_in` in 32: read data from peripheral.

## Operation
- Register map: A1 `0x037F`, A2 `0x0388`, control/status `0x03A0`, W `0x0390`, L `0x0398`. Status bits: [1] ready, [0] valid.
- States: IDLE → WR_A1 → WR_A2 → WR_GO → RD_STAT → (RD_STAT | RD_W | RESP) → RD_W → RD_L → RESP → IDLE.
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid`, latch operands, clear the poll counter, go to WR_A1.
- WR_A1 / WR_A2 / WR_GO: one write access each.
  - Data are `{8'h0,a1}`, `{8'h0,a2}` and `32'h0`.
- RD_STAT: one read access; the sample is evaluated at the end of the access.
  - bit1=1: capture `rsp_ovf` = ~bit0, go to RD_W.
  - bit1=0 and poll count+1 < POLL_LIMIT: increment count, repeat RD_STAT.
  - bit1=0 and limit reached: set `rsp_timeout`=1, `rsp_w`=0, `rsp_l`=0, `rsp_ovf`=0, go to RESP without reading W/L.
- RD_W captures `sdata_in` into `rsp_w`. RD_L captures `sdata_in[23:0]` into `rsp_l`.
- RESP:
  - `rsp_valid`=1; all `rsp_*` held stable.
  - On `rsp_ready`, go to IDLE; `rsp_valid` drops the next cycle.
- A `cmd_valid` asserted outside IDLE is ignored; `cmd_ready`=0 outside IDLE.
- Reset values: `cmd_ready`=1, `rsp_valid`=0, `rsp_w`=0, `rsp_l`=0, `rsp_ovf`=0, `rsp_timeout`=0, `saddress`=0, `sdata_out`=0, `srd`=0, `swr`=0. State is IDLE.

## Timing
- Every access has three phases:
  - SETUP: SETUP_CYCLES cycles, address and data driven, strobe low.
  - STROBE: STROBE_CYCLES cycles, strobe high.
  - HOLD: 1 cycle, strobe low, address and data still held.
  - Access length T = SETUP_CYCLES + STROBE_CYCLES + 1; defaults give 4.
- Read data are sampled on the HOLD cycle edge, at least one full cycle after the strobe's rising edge.
- `srd` and `swr` are never high simultaneously. Strobes are always glitch-free registered outputs.
- Address and data change only in the first SETUP cycle of an access.
- The first SETUP cycle begins the cycle after command acceptance.
- Latency from acceptance to `rsp_valid`: (5 + N)·T cycles, with N = status reads. With defaults and N=1 this is 24 cycles.
- Timeout latency: (3 + POLL_LIMIT)·T.
- `n_reset` mid-access: strobes and outputs reach reset values on that edge. The partial access is abandoned and no response is produced. `n_reset` has priority over all other inputs.
- `rsp_valid` and `rsp_ready` high in the same cycle as a new `cmd_valid`: the response completes first. The command is accepted no earlier than the following cycle (IDLE).

## Test plan
- A1=3, A2=5, responder status 2'b11 on first read, W=15, L=4:
  - Writes observed: `0x037F`/3, `0x0388`/5, `0x03A0`/0.
  - Response: `rsp_w`=15, `rsp_l`=4, `rsp_ovf`=0, `rsp_timeout`=0, `rsp_valid` at cycle 24.
- A1=A2=0xFFFFFF, responder returns status 2'b10, W=0xFE000001, L=8:
  - Response: `rsp_ovf`=1, `rsp_w`=0xFE000001, `rsp_l`=8.
- POLL_LIMIT=4, status stuck at 2'b01:
  - Exactly 4 status reads, no reads of `0x0390`/`0x0398`.
  - Response: `rsp_timeout`=1, `rsp_w`=0, `rsp_l`=0.
- `rsp_ready` held low 10 cycles after `rsp_valid`:
  - Outputs stable, `cmd_ready`=0, and a concurrent `cmd_valid` is ignored.
  - Release → IDLE, `rsp_valid`=0 next cycle.
- `n_reset`=1 during the second STROBE cycle of WR_A2:
  - Next edge: `swr`=0, `saddress`=0, `cmd_ready`=1, `rsp_valid`=0.
  - A new command then runs the full sequence from WR_A1.
- SETUP_CYCLES=2, STROBE_CYCLES=3:
  - Every strobe pulse is exactly 3 cycles wide, preceded by 2 and followed by 1 stable-address cycle.
  - Never `srd`&`swr`.
